// File: rtl/decode.sv
// RV32I decode stage: combinational field/immediate/class decode of the offered
// word, stored into a two-entry (output + skid) buffer towards execute.
module decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_input,
  input  logic [31:0]     data_input,
  input  logic [XLEN-1:0] pc_input,
  output logic            stall_output,
  input  logic            flush_input,
  input  logic            stall_input,
  output logic            valid_output,
  output logic [XLEN-1:0] pc_output,
  output logic [3:0]      class_output,
  output logic [4:0]      rd_output,
  output logic [4:0]      rs1_output,
  output logic [4:0]      rs2_output,
  output logic [2:0]      funct3_output,
  output logic [6:0]      funct7_output,
  output logic [XLEN-1:0] imm_output,
  output logic            reg_write_output,
  output logic            illegal_output,
  output logic [31:0]     decode_count
);

  localparam logic [3:0] CLS_LUI     = 4'd0;
  localparam logic [3:0] CLS_AUIPC   = 4'd1;
  localparam logic [3:0] CLS_JAL     = 4'd2;
  localparam logic [3:0] CLS_JALR    = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_LOAD    = 4'd5;
  localparam logic [3:0] CLS_STORE   = 4'd6;
  localparam logic [3:0] CLS_OPIMM   = 4'd7;
  localparam logic [3:0] CLS_OP      = 4'd8;
  localparam logic [3:0] CLS_FENCE   = 4'd9;
  localparam logic [3:0] CLS_SYSTEM  = 4'd10;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            illegal;
  } bundle_t;

  bundle_t     dec;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;
  logic [3:0]  cls;
  logic        legal;
  logic        writes_rd;

  always_comb begin
    opcode    = data_input[6:0];
    funct3    = data_input[14:12];
    funct7    = data_input[31:25];
    cls       = CLS_ILLEGAL;
    imm32     = '0;
    legal     = 1'b1;
    writes_rd = 1'b0;
    case (opcode)
      7'b0110111: begin
        cls = CLS_LUI; writes_rd = 1'b1;
        imm32 = {data_input[31:12], 12'b0};
      end
      7'b0010111: begin
        cls = CLS_AUIPC; writes_rd = 1'b1;
        imm32 = {data_input[31:12], 12'b0};
      end
      7'b1101111: begin
        cls = CLS_JAL; writes_rd = 1'b1;
        imm32 = {{12{data_input[31]}}, data_input[19:12], data_input[20], data_input[30:21], 1'b0};
      end
      7'b1100111: begin
        cls = CLS_JALR; writes_rd = 1'b1;
        imm32 = {{20{data_input[31]}}, data_input[31:20]};
        legal = (funct3 == 3'b000);
      end
      7'b1100011: begin
        cls = CLS_BRANCH;
        imm32 = {{20{data_input[31]}}, data_input[7], data_input[30:25], data_input[11:8], 1'b0};
        legal = (funct3[2:1] != 2'b01);
      end
      7'b0000011: begin
        cls = CLS_LOAD; writes_rd = 1'b1;
        imm32 = {{20{data_input[31]}}, data_input[31:20]};
        legal = !((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
      end
      7'b0100011: begin
        cls = CLS_STORE;
        imm32 = {{20{data_input[31]}}, data_input[31:25], data_input[11:7]};
        legal = (funct3 <= 3'b010);
      end
      7'b0010011: begin
        cls = CLS_OPIMM; writes_rd = 1'b1;
        imm32 = {{20{data_input[31]}}, data_input[31:20]};
        // shifts reuse the upper immediate bits as funct7
        if (funct3 == 3'b001)
          legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      7'b0110011: begin
        cls = CLS_OP; writes_rd = 1'b1;
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      7'b0001111: cls = CLS_FENCE;
      7'b1110011: cls = CLS_SYSTEM;
      default:    legal = 1'b0;
    endcase
    if (data_input[1:0] != 2'b11)
      legal = 1'b0;

    dec           = '0;
    dec.pc        = pc_input;
    dec.rs1       = data_input[19:15];
    dec.rs2       = data_input[24:20];
    dec.funct3    = funct3;
    dec.funct7    = funct7;
    dec.rd        = data_input[11:7];
    if (legal) begin
      dec.cls       = cls;
      dec.imm       = XLEN'($signed(imm32));
      dec.reg_write = writes_rd && (data_input[11:7] != 5'd0);
      dec.illegal   = 1'b0;
    end else begin
      dec.cls       = CLS_ILLEGAL;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.illegal   = 1'b1;
    end
    if ((dec.cls == CLS_BRANCH) || (dec.cls == CLS_STORE) ||
        (dec.cls == CLS_FENCE)  || (dec.cls == CLS_SYSTEM))
      dec.rd = 5'd0;
  end

  bundle_t     out_q, out_d, skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] count_q, count_d;
  logic        accept;
  logic        out_adv;

  assign accept  = valid_input && !skid_valid_q && !flush_input;
  assign out_adv = !out_valid_q || !stall_input;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    count_d      = count_q;
    if (flush_input) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_valid_q && !stall_input)
        count_d = count_q + 32'd1;
      if (out_adv) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_d       = dec;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      count_q      <= count_d;
    end
  end

  assign valid_output     = out_valid_q;
  assign stall_output     = skid_valid_q;
  assign pc_output        = out_q.pc;
  assign class_output     = out_q.cls;
  assign rd_output        = out_q.rd;
  assign rs1_output       = out_q.rs1;
  assign rs2_output       = out_q.rs2;
  assign funct3_output    = out_q.funct3;
  assign funct7_output    = out_q.funct7;
  assign imm_output       = out_q.imm;
  assign reg_write_output = out_q.reg_write;
  assign illegal_output   = out_q.illegal;
  assign decode_count     = count_q;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: the driver pushes expected bundles on acceptance,
// the monitor compares against the DUT on every cycle and pops on handshake.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_input = 1'b0;
  logic [31:0] data_input = '0;
  logic [31:0] pc_input = '0;
  logic        stall_output;
  logic        flush_input = 1'b0;
  logic        stall_input = 1'b0;
  logic        valid_output;
  logic [31:0] pc_output;
  logic [3:0]  class_output;
  logic [4:0]  rd_output, rs1_output, rs2_output;
  logic [2:0]  funct3_output;
  logic [6:0]  funct7_output;
  logic [31:0] imm_output;
  logic        reg_write_output;
  logic        illegal_output;
  logic [31:0] decode_count;

  always #5 clk = ~clk;

  decode #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_input(valid_input), .data_input(data_input),
    .pc_input(pc_input), .stall_output(stall_output), .flush_input(flush_input),
    .stall_input(stall_input), .valid_output(valid_output), .pc_output(pc_output),
    .class_output(class_output), .rd_output(rd_output), .rs1_output(rs1_output),
    .rs2_output(rs2_output), .funct3_output(funct3_output), .funct7_output(funct7_output),
    .imm_output(imm_output), .reg_write_output(reg_write_output),
    .illegal_output(illegal_output), .decode_count(decode_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  bit          pend = 1'b0;
  bit          after_rst = 1'b1;
  logic [31:0] model_count = '0;
  int          checks = 0;
  int          errors = 0;
  int          txns = 0;

  // Reference decode written from the instruction-set rules with integer arithmetic.
  function automatic exp_t ref_decode(logic [31:0] inst, logic [31:0] pc);
    exp_t       e;
    int         cls;
    int         v;
    bit         ok;
    logic [7:0] f3ok;
    int         sgn4k;
    sgn4k = inst[31] ? 4096 : 0;
    e.pc = pc; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    e.f3 = inst[14:12]; e.f7 = inst[31:25];
    f3ok = 8'hFF; ok = 1'b1; v = 0; cls = 15;
    case (inst[6:0])
      7'h37: begin cls = 0; v = int'(inst & 32'hFFFFF000); end
      7'h17: begin cls = 1; v = int'(inst & 32'hFFFFF000); end
      7'h6F: begin
        cls = 2;
        v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2
            - (inst[31] ? 1048576 : 0);
      end
      7'h67: begin cls = 3; f3ok = 8'h01; v = int'(inst[31:20]) - sgn4k; end
      7'h63: begin
        cls = 4; f3ok = 8'b1111_0011;
        v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2 - sgn4k;
      end
      7'h03: begin cls = 5; f3ok = 8'b0011_0111; v = int'(inst[31:20]) - sgn4k; end
      7'h23: begin
        cls = 6; f3ok = 8'h07;
        v = int'(inst[30:25]) * 32 + int'(inst[11:7]) - (inst[31] ? 2048 : 0);
      end
      7'h13: begin
        cls = 7; v = int'(inst[31:20]) - sgn4k;
        if (e.f3 == 1 && e.f7 != 0) ok = 1'b0;
        if (e.f3 == 5 && !(e.f7 inside {7'h00, 7'h20})) ok = 1'b0;
      end
      7'h33: begin
        cls = 8;
        if (!(e.f7 inside {7'h00, 7'h20})) ok = 1'b0;
        if (e.f7 == 7'h20 && !(e.f3 inside {3'd0, 3'd5})) ok = 1'b0;
      end
      7'h0F: cls = 9;
      7'h73: cls = 10;
      default: ok = 1'b0;
    endcase
    if (inst[1:0] != 2'b11 || !f3ok[inst[14:12]]) ok = 1'b0;
    if (ok) begin
      e.cls = 4'(cls); e.imm = 32'(v); e.ill = 1'b0;
      e.rw  = (cls inside {0, 1, 2, 3, 5, 7, 8}) && (inst[11:7] != 0);
    end else begin
      e.cls = 4'd15; e.imm = '0; e.rw = 1'b0; e.ill = 1'b1;
    end
    e.rd = (e.cls inside {4'd4, 4'd6, 4'd9, 4'd10}) ? 5'd0 : inst[11:7];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; inputs for the next edge too.
  always @(negedge clk) begin
    int in_dut;
    in_dut = exp_q.size() - (pend ? 1 : 0);
    if (after_rst) begin
      chk("rst_ctrl", {31'b0, valid_output, stall_output, class_output, reg_write_output,
                       illegal_output, rd_output, rs1_output, rs2_output, funct3_output,
                       funct7_output}, 64'd0);
      chk("rst_pc", {32'b0, pc_output}, 64'd0);
      chk("rst_imm", {32'b0, imm_output}, 64'd0);
    end
    chk("valid_output", {63'b0, valid_output}, {63'b0, in_dut > 0});
    chk("stall_output", {63'b0, stall_output}, {63'b0, in_dut > 1});
    chk("decode_count", {32'b0, decode_count}, {32'b0, model_count});
    if (valid_output && in_dut > 0) begin
      exp_t e;
      e = exp_q[0];
      chk("pc", {32'b0, pc_output}, {32'b0, e.pc});
      chk("class", {60'b0, class_output}, {60'b0, e.cls});
      chk("rd", {59'b0, rd_output}, {59'b0, e.rd});
      chk("rs1", {59'b0, rs1_output}, {59'b0, e.rs1});
      chk("rs2", {59'b0, rs2_output}, {59'b0, e.rs2});
      chk("funct3", {61'b0, funct3_output}, {61'b0, e.f3});
      chk("funct7", {57'b0, funct7_output}, {57'b0, e.f7});
      chk("imm", {32'b0, imm_output}, {32'b0, e.imm});
      chk("reg_write", {63'b0, reg_write_output}, {63'b0, e.rw});
      chk("illegal", {63'b0, illegal_output}, {63'b0, e.ill});
    end
    if (rst) begin
      exp_q.delete();
      model_count = '0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (flush_input) begin
        exp_q.delete();
      end else if (in_dut > 0 && !stall_input) begin
        txns++;
        $display("txn %0d pc=%08h class=%0d rd=%0d imm=%08h ill=%0b", txns,
                 pc_output, class_output, rd_output, imm_output, illegal_output);
        void'(exp_q.pop_front());
        model_count++;
      end
    end
    pend = 1'b0;
  end

  // One cycle of stimulus; acceptance is decided from the model's occupancy.
  task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                     input logic st, input logic fl, input logic r,
                     input bit use_ex, input exp_t ex, output bit acc);
    valid_input = v; data_input = inst; pc_input = pc;
    stall_input = st; flush_input = fl; rst = r;
    acc = v && !fl && !r && (exp_q.size() < 2);
    if (acc) begin
      exp_q.push_back(use_ex ? ex : ref_decode(inst, pc));
      pend = 1'b1;
    end
    @(posedge clk); #2;
  endtask

  task automatic idle(input logic st, input logic r);
    exp_t d; bit a;
    d = ref_decode(32'h0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, st, 1'b0, r, 1'b0, d, a);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic st);
    exp_t d; bit a;
    d = ref_decode(inst, pc);
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++)
      cyc(1'b1, inst, pc, st, 1'b0, 1'b0, 1'b0, d, a);
    if (!a) begin
      checks++; errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted pc=%08h", pc);
    end
  endtask

  task automatic send_dir(input logic [31:0] inst, input logic [31:0] pc, input logic [3:0] c,
                          input logic [4:0] rd, input logic [31:0] imm, input logic rw,
                          input logic ill);
    exp_t e; bit a;
    e = ref_decode(inst, pc);
    e.cls = c; e.rd = rd; e.imm = imm; e.rw = rw; e.ill = ill;
    cyc(1'b1, inst, pc, 1'b0, 1'b0, 1'b0, 1'b1, e, a);
    if (!a) begin
      checks++; errors++;
      $display("FAIL send_dir: got not-accepted expected accepted pc=%08h", pc);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [0:10];
    logic [31:0] r;
    int          k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom();
    k = $urandom_range(0, 13);
    if (k < 11) begin
      r[6:0] = ops[k];
      if ($urandom_range(0, 1) == 1)
        r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 3) == 0)
        r[11:7] = 5'd0;
    end
    return r;
  endfunction

  initial begin
    exp_t        d;
    bit          a;
    logic [31:0] cur;
    logic [31:0] pc;
    bit          have;
    d = ref_decode(32'h0, 32'h0);
    @(posedge clk); #2;
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    // Directed decode vectors
    send_dir(32'h00500093, 32'h100, 4'd7, 5'd1, 32'h00000005, 1'b1, 1'b0);
    send_dir(32'h123450B7, 32'h104, 4'd0, 5'd1, 32'h12345000, 1'b1, 1'b0);
    send_dir(32'hFE000EE3, 32'h108, 4'd4, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0);
    send_dir(32'h00003067, 32'h10C, 4'd15, 5'd0, 32'h0, 1'b0, 1'b1);
    send_dir(32'h00000000, 32'h110, 4'd15, 5'd0, 32'h0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);

    // Stall: A out, B into skid, C held by fetch until the skid drains
    cyc(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, d, a);
    cyc(1'b1, 32'h00200193, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, d, a);
    cyc(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0, d, a);
    cyc(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0, d, a);
    send(32'h00300213, 32'h208, 1'b0);
    repeat (3) idle(1'b0, 1'b0);

    // Flush with OUT and SKID both full and D offered
    cyc(1'b1, 32'h00400293, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, d, a);
    cyc(1'b1, 32'h00500313, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0, d, a);
    cyc(1'b1, 32'h00600393, 32'h308, 1'b1, 1'b1, 1'b0, 1'b0, d, a);
    repeat (2) idle(1'b0, 1'b0);

    // Reset mid-stall after five instructions, then a normal decode
    idle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send(rand_inst(), 32'h400 + 32'(i * 4), 1'b0);
    repeat (2) idle(1'b0, 1'b0);
    cyc(1'b1, 32'h00700413, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, d, a);
    cyc(1'b1, 32'h00800493, 32'h504, 1'b1, 1'b0, 1'b0, 1'b0, d, a);
    cyc(1'b1, 32'h00900513, 32'h508, 1'b1, 1'b0, 1'b1, 1'b0, d, a);
    send_dir(32'h00500093, 32'h100, 4'd7, 5'd1, 32'h00000005, 1'b1, 1'b0);
    idle(1'b0, 1'b0);

    // Randomized traffic with stalls, flushes and occasional resets
    have = 1'b0; cur = '0; pc = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      logic v, st, fl, r;
      if (!have || $urandom_range(0, 9) < 3) begin
        cur = rand_inst(); pc = pc + 4; have = 1'b1;
      end
      v  = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 299) == 0);
      cyc(v, cur, pc, st, fl, r, 1'b0, d, a);
      if (a) have = 1'b0;
    end
    repeat (4) idle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
